// File: rtl/updown_ring_pkg.sv
// Shared types and helpers for the up/down ring position tracker.
package updown_ring_pkg;

    typedef enum logic {MODE_WRAP, MODE_SAT} ring_mode_t;
    typedef enum logic {DIR_DN, DIR_UP} ring_dir_t;

    function automatic int state_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lap_counter.sv
// Signed two's-complement lap counter; wraps silently at both ends.
module lap_counter #(
    parameter int LAP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [LAP_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + LAP_W'(1);
        end else if (dec && !inc) begin
            count <= count - LAP_W'(1);
        end
    end

    // The ring logic never requests both directions at once.
    a_inc_dec_excl: assert property (
        @(posedge clk) disable iff (rst) !(inc && dec)
    );

endmodule

// File: rtl/updown_ring_fsm.sv
// Modulo-NUM_STATES position register with direction, load, wrap/saturate
// mode, registered wrap pulse and signed lap count.
module updown_ring_fsm
    import updown_ring_pkg::*;
#(
    parameter int  NUM_STATES = 4,
    parameter int  LAP_W      = 8,
    localparam int STATE_W    = state_width(NUM_STATES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               w,
    input  logic               sat_mode,
    input  logic               load,
    input  logic [STATE_W-1:0] load_val,
    output logic [STATE_W-1:0] pos,
    output logic               z,
    output logic               at_max,
    output logic               wrap,
    output logic [LAP_W-1:0]   lap
);

    // One extra bit keeps pos+1 from aliasing before the end compare.
    localparam logic [STATE_W:0] LAST = (STATE_W+1)'(NUM_STATES - 1);
    localparam logic [STATE_W:0] ONE  = (STATE_W+1)'(1);

    ring_mode_t       mode;
    ring_dir_t        dir;
    logic [STATE_W:0] cur;
    logic [STATE_W:0] lv_ext;
    logic [STATE_W:0] nxt;
    logic             wrap_next;
    logic             inc;
    logic             dec;

    assign mode   = ring_mode_t'(sat_mode);
    assign dir    = ring_dir_t'(w);
    assign cur    = {1'b0, pos};
    assign lv_ext = {1'b0, load_val};

    always_comb begin
        nxt       = cur;
        wrap_next = 1'b0;
        inc       = 1'b0;
        dec       = 1'b0;
        if (rst) begin
            nxt = '0;
        end else if (load) begin
            nxt = (lv_ext > LAST) ? LAST : lv_ext;
        end else if (en) begin
            unique case (dir)
                DIR_UP: begin
                    if (cur != LAST) begin
                        nxt = cur + ONE;
                    end else if (mode == MODE_WRAP) begin
                        nxt       = '0;
                        wrap_next = 1'b1;
                        inc       = 1'b1;
                    end
                end
                DIR_DN: begin
                    if (cur != '0) begin
                        nxt = cur - ONE;
                    end else if (mode == MODE_WRAP) begin
                        nxt       = LAST;
                        wrap_next = 1'b1;
                        dec       = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos  <= '0;
            wrap <= 1'b0;
        end else begin
            pos  <= nxt[STATE_W-1:0];
            wrap <= wrap_next;
        end
    end

    assign z      = (pos == '0);
    assign at_max = (cur == LAST);

    a_in_range: assert property (
        @(posedge clk) disable iff (rst) nxt <= LAST
    );

    lap_counter #(
        .LAP_W(LAP_W)
    ) u_lap (
        .clk  (clk),
        .rst  (rst),
        .inc  (inc),
        .dec  (dec),
        .count(lap)
    );

endmodule

// File: tb/tb_updown_ring_fsm.sv
// Bench for updown_ring_fsm: three sizes driven in parallel, table vectors,
// directed corner sequences and randomized traffic against a reference model.
module tb_updown_ring_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic w = 1'b0;
    logic sat_mode = 1'b0;
    logic load = 1'b0;
    int   lv = 0;

    logic [1:0] lv4, pos4;
    logic [2:0] lv5, pos5;
    logic [0:0] lv2, pos2;
    logic       z4, z5, z2, mx4, mx5, mx2, wr4, wr5, wr2;
    logic [7:0] lap4, lap5;
    logic [2:0] lap2;

    assign lv4 = lv[1:0];
    assign lv5 = lv[2:0];
    assign lv2 = lv[0:0];

    always #5 clk = ~clk;

    updown_ring_fsm #(.NUM_STATES(4), .LAP_W(8)) dut4 (
        .clk(clk), .rst(rst), .en(en), .w(w), .sat_mode(sat_mode),
        .load(load), .load_val(lv4), .pos(pos4), .z(z4), .at_max(mx4),
        .wrap(wr4), .lap(lap4)
    );

    updown_ring_fsm #(.NUM_STATES(5), .LAP_W(8)) dut5 (
        .clk(clk), .rst(rst), .en(en), .w(w), .sat_mode(sat_mode),
        .load(load), .load_val(lv5), .pos(pos5), .z(z5), .at_max(mx5),
        .wrap(wr5), .lap(lap5)
    );

    updown_ring_fsm #(.NUM_STATES(2), .LAP_W(3)) dut2 (
        .clk(clk), .rst(rst), .en(en), .w(w), .sat_mode(sat_mode),
        .load(load), .load_val(lv2), .pos(pos2), .z(z2), .at_max(mx2),
        .wrap(wr2), .lap(lap2)
    );

    int compared = 0;
    int mismatched = 0;

    // Reference model: position as an integer in 0..n-1, lap kept modulo 2^lw.
    int nst[3] = '{4, 5, 2};
    int lw[3]  = '{8, 8, 3};
    int lvw[3] = '{2, 3, 1};
    int mpos[3];
    int mlap[3];
    int mwrap[3];

    function automatic int msk(input int v, input int b);
        return v & ((1 << b) - 1);
    endfunction

    function automatic int g_pos(input int k);
        if (k == 0) return int'(pos4);
        if (k == 1) return int'(pos5);
        return int'(pos2);
    endfunction

    function automatic int g_lap(input int k);
        if (k == 0) return int'(lap4);
        if (k == 1) return int'(lap5);
        return int'(lap2);
    endfunction

    function automatic int g_wrap(input int k);
        if (k == 0) return int'(wr4);
        if (k == 1) return int'(wr5);
        return int'(wr2);
    endfunction

    function automatic int g_z(input int k);
        if (k == 0) return int'(z4);
        if (k == 1) return int'(z5);
        return int'(z2);
    endfunction

    function automatic int g_mx(input int k);
        if (k == 0) return int'(mx4);
        if (k == 1) return int'(mx5);
        return int'(mx2);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int n;
            int v;
            n = nst[k];
            v = msk(lv, lvw[k]);
            mwrap[k] = 0;
            if (rst) begin
                mpos[k] = 0;
                mlap[k] = 0;
            end else if (load) begin
                mpos[k] = (v >= n) ? n - 1 : v;
            end else if (en && w) begin
                if (mpos[k] < n - 1) begin
                    mpos[k] = mpos[k] + 1;
                end else if (!sat_mode) begin
                    mpos[k] = 0;
                    mwrap[k] = 1;
                    mlap[k] = msk(mlap[k] + 1, lw[k]);
                end
            end else if (en && !w) begin
                if (mpos[k] > 0) begin
                    mpos[k] = mpos[k] - 1;
                end else if (!sat_mode) begin
                    mpos[k] = n - 1;
                    mwrap[k] = 1;
                    mlap[k] = msk(mlap[k] - 1, lw[k]);
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic check_model(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s n%0d pos", tag, nst[k]), g_pos(k), mpos[k]);
            chk($sformatf("%s n%0d wrap", tag, nst[k]), g_wrap(k), mwrap[k]);
            chk($sformatf("%s n%0d lap", tag, nst[k]), g_lap(k), mlap[k]);
            chk($sformatf("%s n%0d z", tag, nst[k]), g_z(k), int'(mpos[k] == 0));
            chk($sformatf("%s n%0d at_max", tag, nst[k]), g_mx(k),
                int'(mpos[k] == nst[k] - 1));
        end
    endtask

    typedef struct {
        int rst, load, en, w, sat, lv;
        int pos, wrap, lap, z, mx;
    } vec_t;

    vec_t tv[$];

    initial begin
        // NUM_STATES=4: reset, wrap up, then saturate at the top.
        tv.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0});
        tv.push_back('{0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0});
        tv.push_back('{0, 0, 1, 1, 0, 0, 2, 0, 0, 0, 0});
        tv.push_back('{0, 0, 1, 1, 0, 0, 3, 0, 0, 0, 1});
        tv.push_back('{0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0});
        tv.push_back('{0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0});
        tv.push_back('{0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0});
        tv.push_back('{0, 1, 0, 0, 1, 3, 3, 0, 1, 0, 1});
        tv.push_back('{0, 0, 1, 1, 1, 0, 3, 0, 1, 0, 1});
        tv.push_back('{0, 0, 1, 1, 1, 0, 3, 0, 1, 0, 1});
        tv.push_back('{0, 0, 1, 1, 1, 0, 3, 0, 1, 0, 1});
        tv.push_back('{0, 0, 1, 0, 1, 0, 2, 0, 1, 0, 0});

        for (int i = 0; i < tv.size(); i++) begin
            rst = tv[i].rst[0];
            load = tv[i].load[0];
            en = tv[i].en[0];
            w = tv[i].w[0];
            sat_mode = tv[i].sat[0];
            lv = tv[i].lv;
            cyc();
            chk($sformatf("vec%0d pos", i), int'(pos4), tv[i].pos);
            chk($sformatf("vec%0d wrap", i), int'(wr4), tv[i].wrap);
            chk($sformatf("vec%0d lap", i), int'(lap4), msk(tv[i].lap, 8));
            chk($sformatf("vec%0d z", i), int'(z4), tv[i].z);
            chk($sformatf("vec%0d at_max", i), int'(mx4), tv[i].mx);
        end

        // NUM_STATES=5: wrap down from 0.
        rst = 1; load = 0; en = 0; sat_mode = 0; lv = 0;
        cyc();
        rst = 0; en = 1; w = 0;
        cyc();
        chk("dn5 pos", int'(pos5), 4);
        chk("dn5 wrap", int'(wr5), 1);
        chk("dn5 lap", int'(lap5), 8'hFF);
        chk("dn5 at_max", int'(mx5), 1);
        cyc();
        chk("dn5b pos", int'(pos5), 3);
        chk("dn5b wrap", int'(wr5), 0);
        chk("dn5b lap", int'(lap5), 8'hFF);

        // NUM_STATES=5: load wins over en and clamps, then wrap up.
        load = 1; lv = 7; en = 1; w = 1;
        cyc();
        chk("ld5 pos", int'(pos5), 4);
        chk("ld5 wrap", int'(wr5), 0);
        chk("ld5 lap", int'(lap5), 8'hFF);
        load = 0;
        cyc();
        chk("ld5 step pos", int'(pos5), 0);
        chk("ld5 step wrap", int'(wr5), 1);
        chk("ld5 step lap", int'(lap5), 0);
        chk("ld5 step z", int'(z5), 1);

        // NUM_STATES=2, LAP_W=3: every second up-step wraps; lap overflows.
        rst = 1; en = 0; lv = 0;
        cyc();
        rst = 0; en = 1; w = 1;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            chk($sformatf("ovf%0d pos", i), int'(pos2), i % 2);
            chk($sformatf("ovf%0d wrap", i), int'(wr2), int'(i % 2 == 0));
            chk($sformatf("ovf%0d lap", i), int'(lap2), msk(i / 2, 3));
        end

        // Mid-run reset beats load and en.
        rst = 1; load = 1; lv = 2; en = 1;
        cyc();
        chk("mrst pos4", int'(pos4), 0);
        chk("mrst lap4", int'(lap4), 0);
        chk("mrst wrap4", int'(wr4), 0);
        chk("mrst z4", int'(z4), 1);
        chk("mrst pos5", int'(pos5), 0);
        chk("mrst lap2", int'(lap2), 0);

        // Randomized traffic on all three sizes against the model.
        load = 0; en = 0;
        cyc();
        rst = 0;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            load = ($urandom_range(0, 7) == 0);
            en = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1) == 1;
            sat_mode = ($urandom_range(0, 4) == 0);
            lv = int'($urandom_range(0, 7));
            cyc();
            check_model($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
